// File: rtl/sec_word_encoder.sv
// SEC check-bit encoder: 1-cycle registered output with a one-entry skid buffer and
// a one-shot single-bit error injector for exercising the downstream decoder.
module sec_word_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             inj_arm,
    input  logic [5:0]       inj_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [7:0]       out_chk,
    output logic             out_en,
    output logic             inj_done,
    output logic [CNT_W-1:0] word_cnt
);

    function automatic logic [7:0] calc_chk(input logic [31:0] d);
        logic [7:0] c;
        c[0] = d[0]  ^ d[4]  ^ d[8]  ^ d[12] ^ (^d[23:16]);
        c[1] = d[1]  ^ d[5]  ^ d[9]  ^ d[13] ^ (^d[31:24]);
        c[2] = d[2]  ^ d[6]  ^ d[10] ^ d[14] ^ (^d[19:16]) ^ (^d[27:24]);
        c[3] = d[3]  ^ d[7]  ^ d[11] ^ d[15] ^ (^d[23:20]) ^ (^d[31:28]);
        c[4] = d[16] ^ d[20] ^ d[24] ^ d[28] ^ (^d[7:0]);
        c[5] = d[17] ^ d[21] ^ d[25] ^ d[29] ^ (^d[15:8]);
        c[6] = d[18] ^ d[22] ^ d[26] ^ d[30] ^ (^d[3:0])  ^ (^d[11:8]);
        c[7] = d[19] ^ d[23] ^ d[27] ^ d[31] ^ (^d[7:4])  ^ (^d[15:12]);
        return c;
    endfunction

    // Stored words are packed as {chk, data} so an injection index maps directly to a bit.
    logic [39:0]      out_word_q, out_word_d;
    logic             out_vld_q, out_vld_d;
    logic [39:0]      skid_word_q, skid_word_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_rdy_q, in_rdy_d;
    logic             inj_pend_q, inj_pend_d;
    logic [5:0]       inj_idx_q, inj_idx_d;
    logic             inj_done_q, inj_done_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic        in_hs;
    logic        out_hs;
    logic        flip_now;
    logic        arm_ok;
    logic [39:0] flip_mask;
    logic [39:0] enc_word;

    always_comb begin
        in_hs     = in_valid & in_rdy_q;
        out_hs    = out_vld_q & out_ready;
        // A pending flip only ever comes from an earlier cycle's arm, so a same-cycle
        // arm never touches the word accepted alongside it.
        flip_now  = in_hs & inj_pend_q;
        arm_ok    = inj_arm & (inj_idx < 6'd40);
        flip_mask = flip_now ? (40'd1 << inj_idx_q) : 40'd0;
        enc_word  = {calc_chk(in_data), in_data} ^ flip_mask;

        out_word_d  = out_word_q;
        out_vld_d   = out_vld_q;
        skid_word_d = skid_word_q;
        skid_vld_d  = skid_vld_q;
        inj_pend_d  = inj_pend_q;
        inj_idx_d   = inj_idx_q;
        inj_done_d  = flip_now;
        word_cnt_d  = word_cnt_q;

        if (out_hs) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (skid_vld_q) begin
                out_word_d = skid_word_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d  = 1'b0;
            end
        end

        // in_hs implies SKID is empty, so OUT is the target unless it stays occupied.
        if (in_hs) begin
            if (!out_vld_q || out_hs) begin
                out_word_d = enc_word;
                out_vld_d  = 1'b1;
            end else begin
                skid_word_d = enc_word;
                skid_vld_d  = 1'b1;
            end
        end

        if (arm_ok) begin
            inj_pend_d = 1'b1;
            inj_idx_d  = inj_idx;
        end else if (flip_now) begin
            inj_pend_d = 1'b0;
        end

        in_rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_word_q  <= 40'd0;
            out_vld_q   <= 1'b0;
            skid_word_q <= 40'd0;
            skid_vld_q  <= 1'b0;
            in_rdy_q    <= 1'b1;
            inj_pend_q  <= 1'b0;
            inj_idx_q   <= 6'd0;
            inj_done_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            out_word_q  <= out_word_d;
            out_vld_q   <= out_vld_d;
            skid_word_q <= skid_word_d;
            skid_vld_q  <= skid_vld_d;
            in_rdy_q    <= in_rdy_d;
            inj_pend_q  <= inj_pend_d;
            inj_idx_q   <= inj_idx_d;
            inj_done_q  <= inj_done_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign out_en    = out_vld_q;
    assign out_data  = out_word_q[31:0];
    assign out_chk   = out_word_q[39:32];
    assign inj_done  = inj_done_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_sec_word_encoder.sv
// Bench for sec_word_encoder: directed scenarios plus random traffic against a
// queue-based reference model with mask-table check-bit generation.
module tb_sec_word_encoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = 32'd0;
    logic             inj_arm = 1'b0;
    logic [5:0]       inj_idx = 6'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [7:0]       out_chk;
    logic             out_en;
    logic             inj_done;
    logic [CNT_W-1:0] word_cnt;

    sec_word_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inj_arm(inj_arm), .inj_idx(inj_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chk(out_chk), .out_en(out_en),
        .inj_done(inj_done), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [39:0] exp_q[$];
    logic        m_pend = 1'b0;
    int          m_idx  = 0;
    logic        m_done = 1'b0;
    int          m_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Each check bit is the parity of the data bits selected by a mask built from the rules.
    function automatic logic [7:0] ref_chk(input logic [31:0] d);
        logic [31:0] m [8];
        logic [7:0]  c;
        for (int i = 0; i < 4; i++) begin
            m[i]     = 32'h0000_1111 << i;
            m[i + 4] = 32'h1111_0000 << i;
        end
        m[0] |= 32'h00FF_0000;
        m[1] |= 32'hFF00_0000;
        m[2] |= 32'h0F0F_0000;
        m[3] |= 32'hF0F0_0000;
        m[4] |= 32'h0000_00FF;
        m[5] |= 32'h0000_FF00;
        m[6] |= 32'h0000_0F0F;
        m[7] |= 32'h0000_F0F0;
        for (int i = 0; i < 8; i++) c[i] = ($countones(d & m[i]) % 2) == 1;
        return c;
    endfunction

    // One clock: check visible state at the falling edge, advance the model, then
    // return just after the rising edge with inj_arm cleared.
    task automatic step();
        logic [39:0] w;
        logic        acc, ohs;
        @(negedge clk);
        check("out_valid", out_valid, exp_q.size() > 0);
        check("out_en", out_en, exp_q.size() > 0);
        check("in_ready", in_ready, exp_q.size() < 2);
        check("inj_done", inj_done, m_done);
        check("word_cnt", word_cnt, m_cnt % 16);
        if (exp_q.size() > 0) begin
            check("out_data", out_data, exp_q[0][31:0]);
            check("out_chk", out_chk, exp_q[0][39:32]);
        end
        ohs    = (exp_q.size() > 0) && out_ready;
        acc    = in_valid && (exp_q.size() < 2);
        m_done = 1'b0;
        if (ohs) begin
            void'(exp_q.pop_front());
            m_cnt = (m_cnt + 1) % 16;
        end
        if (acc) begin
            w = {ref_chk(in_data), in_data};
            if (m_pend) begin
                w[m_idx] = ~w[m_idx];
                m_pend   = 1'b0;
                m_done   = 1'b1;
            end
            exp_q.push_back(w);
        end
        if (inj_arm && inj_idx < 40) begin
            m_pend = 1'b1;
            m_idx  = int'(inj_idx);
        end
        @(posedge clk);
        #1;
        inj_arm = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_en", out_en, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chk", out_chk, 0);
        check("rst_inj_done", inj_done, 0);
        exp_q.delete();
        m_pend = 1'b0;
        m_done = 1'b0;
        m_cnt  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        apply_reset();

        // Known vectors, streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 32'h0000_0001; step(); check("vec1_chk", out_chk, 8'h51);
        in_data = 32'h0001_0000; step(); check("vec2_chk", out_chk, 8'h15);
        in_data = 32'hFFFF_FFFF; step(); check("vec3_chk", out_chk, 8'h00);
        in_valid = 1'b0; step(); check("vec_cnt3", word_cnt, 3);

        // Data-bit injection
        inj_arm = 1'b1; inj_idx = 6'd5; step();
        in_valid = 1'b1; in_data = 32'd0; step();
        check("inj5_data", out_data, 32'h20);
        check("inj5_chk", out_chk, 8'h00);
        check("inj5_done", inj_done, 1);
        step();
        check("inj5_next_clean", out_data, 32'h0);
        check("inj5_done_once", inj_done, 0);
        in_valid = 1'b0; step();

        // Check-bit injection, then an out-of-range arm
        inj_arm = 1'b1; inj_idx = 6'd33; step();
        in_valid = 1'b1; step(); check("inj33_chk", out_chk, 8'h02);
        in_valid = 1'b0; inj_arm = 1'b1; inj_idx = 6'd45; step();
        in_valid = 1'b1; step();
        check("inj45_chk", out_chk, 8'h00);
        check("inj45_done", inj_done, 0);
        in_valid = 1'b0; step();

        // Arm in the same cycle as W1 is accepted: only W2 is flipped
        in_valid = 1'b1; in_data = 32'hA5A5_0F0F; inj_arm = 1'b1; inj_idx = 6'd0; step();
        check("coll_w1", out_data, 32'hA5A5_0F0F);
        in_data = 32'h1234_5678; step();
        check("coll_w2", out_data, 32'h1234_5679);
        in_valid = 1'b0; step();

        // Backpressure: A in OUT, B in SKID, C held until drained
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'hAAAA_0001; step();
        in_data = 32'hBBBB_0002; step();
        check("bp_ready_low", in_ready, 0);
        in_data = 32'hCCCC_0003; step(); step();
        check("bp_hold_a", out_data, 32'hAAAA_0001);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && in_valid; i++) begin
            if (exp_q.size() < 2) begin
                step();
                in_valid = 1'b0;
            end else begin
                step();
            end
        end
        check("bp_c_taken", in_valid, 0);
        for (int i = 0; i < 4; i++) step();
        check("bp_ready_high", in_ready, 1);
        check("bp_drained", out_valid, 0);

        // Random traffic with occasional injections
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            inj_arm   = ($urandom_range(0, 9) == 0);
            inj_idx   = 6'($urandom_range(0, 63));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Counter wrap after 17 handshakes
        @(negedge clk);
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("wrap_cnt", word_cnt, 1);

        // Mid-stream reset with OUT and SKID full and an injection pending
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h1111_1111; step();
        in_data = 32'h2222_2222; inj_arm = 1'b1; inj_idx = 6'd7; step();
        in_valid = 1'b0; step();
        check("pre_rst_full", in_ready, 0);
        #2;
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0; step();
        check("post_rst_clean", out_data, 32'h0);
        in_valid = 1'b0; step();
        check("post_rst_no_done", inj_done, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sec_word_encoder.md
# sec_word_encoder

Upstream companion to the 32-bit single-error-correcting (SEC) decode stage. It accepts 32-bit data words over a valid/ready handshake and computes the 8 check bits that the decoder expects. It drives each word with its check bits and the check-enable bit, registered, with a skid buffer for full-throughput backpressure. A one-shot error-injection facility flips a selected data or check bit so benches can exercise the decoder's correction path.

## Interface
- CNT_W, 16, width of the delivered-word counter.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block can accept a word; registered.
- in_data  in  32  data bits d0..d31 (d0 = in_data[0]).
- inj_arm  in  1  one-cycle pulse: latch inj_idx for the next accepted word.
- inj_idx  in  6  bit to flip: 0..31 = data bit, 32..39 = check bit (idx-32), 40..63 = ignored.
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts output word.
- out_data  out  32  data bits, possibly with one injected flip.
- out_chk  out  8  check bits c0..c7, possibly with one injected flip.
- out_en  out  1  check enable to decoder; equals out_valid.
- inj_done  out  1  one-cycle pulse: an injected word was loaded into the pipeline.
- word_cnt  out  CNT_W  count of output handshakes, wraps modulo 2^CNT_W.

## Operation
- Check bits, with "x..y" meaning the XOR of the contiguous data bits dx through dy:
  - c0 = d0^d4^d8^d12 ^ d16..d23
  - c1 = d1^d5^d9^d13 ^ d24..d31
  - c2 = d2^d6^d10^d14 ^ d16..d19 ^ d24..d27
  - c3 = d3^d7^d11^d15 ^ d20..d23 ^ d28..d31
  - c4 = d16^d20^d24^d28 ^ d0..d7
  - c5 = d17^d21^d25^d29 ^ d8..d15
  - c6 = d18^d22^d26^d30 ^ d0..d3 ^ d8..d11
  - c7 = d19^d23^d27^d31 ^ d4..d7 ^ d12..d15
- The check bits are computed on the clean input word. An injected flip is applied afterwards, so the decoder sees exactly one error.
- Storage: the output register (OUT) plus one skid register (SKID), each holding {data, chk, valid}.
- An input handshake occurs when in_valid and in_ready are both 1. An output handshake occurs when out_valid and out_ready are both 1.
- On an input handshake, the encoded word goes to OUT if OUT is empty or being drained this cycle (and SKID is empty). Otherwise it goes to SKID.
- On an output handshake with SKID full, SKID moves to OUT and SKID empties.
- in_ready = ~SKID.valid, registered. in_ready drops the cycle after SKID fills.
- Word order is preserved strictly.
- Injection:
  - inj_arm with inj_idx < 40 sets a pending flag and stores the index. A later arm overwrites a pending index.
  - inj_arm with inj_idx >= 40 is ignored and leaves any pending request intact.
  - The pending flip is applied to the first word accepted in a cycle after the arm cycle. If inj_arm and an input handshake occur in the same cycle, the flip applies to the next word, not this one.
  - inj_done pulses in the cycle after the flipped word is captured. The pending flag clears at that same edge.
- word_cnt increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.

## Timing
- Latency: 1 cycle. A word accepted at edge N appears on out_* after edge N when OUT was free.
- Sustained throughput is 1 word/cycle while out_ready=1.
- out_valid=1 with out_ready=0 holds out_data, out_chk and out_en stable until the handshake.
- Reset values: out_valid=0, out_en=0, out_data=0, out_chk=0, in_ready=1, inj_done=0, word_cnt=0, SKID empty, no injection pending.
- Reset asserted mid-stream discards both stored words and any pending injection immediately. No output handshake is counted for discarded words.
- Combinational paths: none from out_ready to in_ready, and none from in_* to out_*.

## Test plan
- Reset, then send in_data=0x00000001, 0x00010000, 0xFFFFFFFF with out_ready=1:
  - out_chk = 0x51, 0x15, 0x00, on consecutive cycles starting 1 cycle after each accept.
  - out_en=1 with each word.
  - word_cnt ends at 3.
- Data-bit injection: inj_arm with inj_idx=5, then send 0x00000000 -> out_data=0x00000020, out_chk=0x00, inj_done pulses once. The following word is clean.
- Check-bit injection and ignored arm: inj_arm with inj_idx=33, then send 0 -> out_chk=0x02. A separate inj_arm with inj_idx=45 produces no flip and no inj_done.
- Backpressure: hold out_ready=0 with in_valid=1 streaming A, B, C:
  - A sits in OUT and B in SKID; in_ready goes low and C is held.
  - Raise out_ready: A, B, C emerge in order with no loss or duplication, and in_ready returns high.
- Wrap and reset: with CNT_W=4, complete 17 handshakes -> word_cnt=1. Assert rst while OUT and SKID are full -> out_valid=0 and in_ready=1 immediately, word_cnt=0.
- Arm/accept collision: inj_arm (idx=0) in the same cycle as accepting word W1, then accept W2 -> W1 is unflipped and W2 has data bit 0 inverted.
